switch_arb: RTL and testbench

SWITCH_ARB -- requirements
Module: switch_arb

---
 rtl/switch_arb_pkg.sv | 16 +
 rtl/switch_arb_stats.sv | 20 ++
 rtl/switch_arb.sv | 126 ++++++++++++
 tb/tb_switch_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_arb_pkg.sv
// switch_arb shared types: FSM state encoding (doubles as the grant code), requester id, defaults.
// No logic.
package switch_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   typedef logic req_id_t;

   localparam int BURST_MAX_DEF = 4;
   localparam int CNT_W         = 16;

endpackage

// File: rtl/switch_arb_stats.sv
// Saturating event counter; inc counts on the same edge, 1-cycle visible latency.
// No backpressure: once at all-ones it holds.
module switch_arb_stats
   import switch_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/switch_arb.sv
// 2:1 burst-limited arbiter into one registered output slot; accept->out_vld is 1 cycle.
// req*_rdy drops while the held word is stalled by out_rdy; SWITCH_ARB_STATS_EN adds counters.
module switch_arb
   import switch_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_MAX  = BURST_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req0_vld,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_rdy,
   input  logic                  req1_vld,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_rdy,
   output logic                  out_vld,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_rdy,
   output logic [1:0]            grant,
   output logic [CNT_W-1:0]      cnt0,
   output logic [CNT_W-1:0]      cnt1
);

   localparam int BW = $clog2(BURST_MAX + 1);

   state_t          state, state_nxt;
   req_id_t         last_owner;
   logic [BW-1:0]   burst_cnt, burst_nxt;
   logic            slot_free;
   logic            xfer0, xfer1;
   logic            burst_full;

   assign slot_free  = !out_vld || out_rdy;
   assign req0_rdy   = (state == OWN0) && slot_free;
   assign req1_rdy   = (state == OWN1) && slot_free;
   assign xfer0      = req0_vld && req0_rdy;
   assign xfer1      = req1_vld && req1_rdy;
   assign burst_full = (burst_cnt == BW'(BURST_MAX - 1));
   assign grant      = state;

   // A full burst only hands over when the other side is waiting; otherwise the owner keeps streaming.
   always_comb begin
      state_nxt = state;
      burst_nxt = burst_cnt;
      case (state)
         IDLE: begin
            if (req0_vld && req1_vld) begin
               state_nxt = (last_owner == 1'b0) ? OWN1 : OWN0;
            end else if (req0_vld) begin
               state_nxt = OWN0;
            end else if (req1_vld) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (!req0_vld) begin
               state_nxt = req1_vld ? OWN1 : IDLE;
            end else if (xfer0 && burst_full) begin
               burst_nxt = '0;
               if (req1_vld) state_nxt = OWN1;
            end else if (xfer0) begin
               burst_nxt = burst_cnt + 1'b1;
            end
         end
         OWN1: begin
            if (!req1_vld) begin
               state_nxt = req0_vld ? OWN0 : IDLE;
            end else if (xfer1 && burst_full) begin
               burst_nxt = '0;
               if (req0_vld) state_nxt = OWN0;
            end else if (xfer1) begin
               burst_nxt = burst_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) burst_nxt = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         burst_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
         if (state_nxt != state) begin
            if (state_nxt == OWN0) last_owner <= 1'b0;
            if (state_nxt == OWN1) last_owner <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_vld  <= 1'b0;
         out_addr <= '0;
         out_data <= '0;
      end else if (xfer0) begin
         out_vld  <= 1'b1;
         out_addr <= req0_addr;
         out_data <= req0_data;
      end else if (xfer1) begin
         out_vld  <= 1'b1;
         out_addr <= req1_addr;
         out_data <= req1_data;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

`ifdef SWITCH_ARB_STATS_EN
   switch_arb_stats u_stats0 (.clk(clk), .rstn(rstn), .inc(xfer0), .cnt(cnt0));
   switch_arb_stats u_stats1 (.clk(clk), .rstn(rstn), .inc(xfer1), .cnt(cnt1));
`else
   assign cnt0 = '0;
   assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_switch_arb.sv
// Bench for switch_arb: vector table, hand-written corner sequences, randomized run against a cycle model.
module tb_switch_arb;

   localparam int BM = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_vld, req1_vld, req0_rdy, req1_rdy;
   logic [7:0]  req0_addr, req1_addr, out_addr;
   logic [15:0] req0_data, req1_data, out_data;
   logic        out_vld, out_rdy;
   logic [1:0]  grant;
   logic [15:0] cnt0, cnt1;

`ifdef SWITCH_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   switch_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .BURST_MAX(BM)) dut (
      .clk(clk), .rstn(rstn),
      .req0_vld(req0_vld), .req0_addr(req0_addr), .req0_data(req0_data), .req0_rdy(req0_rdy),
      .req1_vld(req1_vld), .req1_addr(req1_addr), .req1_data(req1_data), .req1_rdy(req1_rdy),
      .out_vld(out_vld), .out_addr(out_addr), .out_data(out_data), .out_rdy(out_rdy),
      .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: owner -1 = nobody, otherwise requester index.
   int          m_owner, m_last, m_burst, m_c0, m_c1;
   bit          m_ov;
   logic [7:0]  m_oa;
   logic [15:0] m_od;

   function automatic void m_reset();
      m_owner = -1; m_last = 1; m_burst = 0;
      m_ov = 0; m_oa = '0; m_od = '0; m_c0 = 0; m_c1 = 0;
   endfunction

   task automatic drive_idle();
      req0_vld = 0; req1_vld = 0; out_rdy = 0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
   endtask

   task automatic do_reset();
      rstn = 0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rstn = 1;
      m_reset();
   endtask

   task automatic model_cycle();
      bit e_r0, e_r1, x0, x1;
      bit vv [2];
      int nxt, o, y, egr;
      @(negedge clk);
      e_r0 = (m_owner == 0) && (!m_ov || out_rdy);
      e_r1 = (m_owner == 1) && (!m_ov || out_rdy);
      egr  = (m_owner < 0) ? 0 : (m_owner == 0 ? 1 : 2);
      chk("rnd_rdy0", req0_rdy, e_r0);
      chk("rnd_rdy1", req1_rdy, e_r1);
      chk("rnd_grant", grant, egr);
      chk("rnd_out_vld", out_vld, m_ov);
      if (m_ov) begin
         chk("rnd_out_addr", out_addr, m_oa);
         chk("rnd_out_data", out_data, m_od);
      end
      chk("rnd_cnt0", cnt0, STATS ? m_c0 : 0);
      chk("rnd_cnt1", cnt1, STATS ? m_c1 : 0);
      vv[0] = req0_vld; vv[1] = req1_vld;
      x0 = req0_vld && e_r0;
      x1 = req1_vld && e_r1;
      if (x0) begin m_ov = 1; m_oa = req0_addr; m_od = req0_data; end
      else if (x1) begin m_ov = 1; m_oa = req1_addr; m_od = req1_data; end
      else if (out_rdy) m_ov = 0;
      if (x0 && m_c0 < 65535) m_c0++;
      if (x1 && m_c1 < 65535) m_c1++;
      if (m_owner < 0) begin
         if (vv[0] && vv[1]) nxt = 1 - m_last;
         else if (vv[0])     nxt = 0;
         else if (vv[1])     nxt = 1;
         else                nxt = -1;
      end else begin
         o = m_owner; y = 1 - o;
         nxt = o;
         if (!vv[o]) nxt = vv[y] ? y : -1;
         else if (x0 || x1) begin
            m_burst++;
            if (m_burst == BM) begin
               m_burst = 0;
               if (vv[y]) nxt = y;
            end
         end
      end
      if (nxt != m_owner) begin
         m_burst = 0;
         if (nxt >= 0) m_last = nxt;
      end
      m_owner = nxt;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic v0, v1; logic [7:0] a0, a1; logic [15:0] d0, d1; logic ordy;
      logic r0, r1; logic [1:0] g; logic ov; logic [7:0] oa; logic [15:0] od;
   } vec_t;

   vec_t tbl [11];
   int   seq [16];

   initial begin
      int n, idle, cyc, prev;
      bit started, have, after, done;

      tbl[0]  = '{1'b1, 1'b0, 8'h10, 8'h00, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 16'hAAAA, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 8'h11, 8'h00, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'h10, 16'hAAAA};
      tbl[3]  = '{1'b1, 1'b0, 8'h11, 8'h00, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'h10, 16'hAAAA};
      tbl[4]  = '{1'b1, 1'b0, 8'h11, 8'h00, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'h10, 16'hAAAA};
      tbl[5]  = '{1'b1, 1'b0, 8'h11, 8'h00, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h10, 16'hAAAA};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h11, 16'h1111};
      tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'h20, 16'h0000, 16'h2222, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 16'h0000};
      tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h20, 16'h0000, 16'h2222, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 16'h0000};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 8'h20, 16'h2222};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 16'h0000};

      // Reset state, sampled while rstn is held low
      rstn = 0;
      drive_idle();
      req0_vld = 1; req1_vld = 1; out_rdy = 1;
      @(negedge clk);
      chk("reset_grant", grant, 0);
      chk("reset_out_vld", out_vld, 0);
      chk("reset_out_addr", out_addr, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_rdy0", req0_rdy, 0);
      chk("reset_rdy1", req1_rdy, 0);
      chk("reset_cnt0", cnt0, 0);
      chk("reset_cnt1", cnt1, 0);

      // Vector table: single requester, output stall, handoff through idle
      do_reset();
      for (int i = 0; i < 11; i++) begin
         req0_vld = tbl[i].v0; req1_vld = tbl[i].v1;
         req0_addr = tbl[i].a0; req1_addr = tbl[i].a1;
         req0_data = tbl[i].d0; req1_data = tbl[i].d1;
         out_rdy = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d_rdy0", i), req0_rdy, tbl[i].r0);
         chk($sformatf("vec%0d_rdy1", i), req1_rdy, tbl[i].r1);
         chk($sformatf("vec%0d_grant", i), grant, tbl[i].g);
         chk($sformatf("vec%0d_out_vld", i), out_vld, tbl[i].ov);
         if (tbl[i].ov) begin
            chk($sformatf("vec%0d_out_addr", i), out_addr, tbl[i].oa);
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
         end
         @(posedge clk);
         #1;
      end

      // Both requesting from reset: 4/4 alternation with no gap
      do_reset();
      req0_vld = 1; req1_vld = 1; out_rdy = 1;
      n = 0; idle = 0; started = 0;
      for (int c = 0; c < 40 && n < 16; c++) begin
         @(negedge clk);
         if (req0_rdy) begin seq[n] = 0; n++; started = 1; end
         else if (req1_rdy) begin seq[n] = 1; n++; started = 1; end
         else if (started) idle++;
         @(posedge clk);
         #1;
      end
      chk("burst_count", n, 16);
      chk("burst_idle_cycles", idle, 0);
      for (int i = 0; i < n; i++) chk($sformatf("burst_owner%0d", i), seq[i], (i / 4) % 2);

      // req1 alone streams 6 words across the burst wrap
      do_reset();
      req1_vld = 1; out_rdy = 1; req1_data = 16'h0100;
      n = 0; have = 0; cyc = 0; prev = 0;
      while (cyc < 12 && n < 6) begin
         @(negedge clk);
         if (have) chk("stream_word", out_data, prev);
         have = 0;
         if (req1_rdy) begin
            chk("stream_grant", grant, 2);
            prev = req1_data; have = 1; n++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (have) req1_data = req1_data + 1;
      end
      chk("stream_words", n, 6);
      chk("stream_cycles", cyc, 7);
      @(negedge clk);
      chk("stream_last_word", out_data, prev);
      chk("stream_hold_grant", grant, 2);
      @(posedge clk);
      #1;

      // req0 arrives while req1 offers its 4th word: handoff right after it
      do_reset();
      req1_vld = 1; out_rdy = 1;
      n = 0; after = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (n >= 3) req0_vld = 1;
         @(negedge clk);
         if (req1_rdy && req1_vld) begin
            n++;
            if (n == 4) after = 1;
         end else if (after) begin
            chk("handoff_grant", grant, 1);
            chk("handoff_rdy0", req0_rdy, 1);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      chk("handoff_seen", done, 1);
      chk("handoff_req1_words", n, 4);

      // Asynchronous reset mid-burst, then priority back to req0
      do_reset();
      req0_vld = 1; req1_vld = 1; out_rdy = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_pre_out_vld", out_vld, 1);
      rstn = 0;
      #1;
      chk("rst_out_vld", out_vld, 0);
      chk("rst_grant", grant, 0);
      chk("rst_rdy0", req0_rdy, 0);
      chk("rst_rdy1", req1_rdy, 0);
      @(posedge clk);
      #1 rstn = 1;
      @(negedge clk);
      chk("rst_release_idle", grant, 0);
      @(negedge clk);
      chk("rst_first_grant", grant, 1);
      chk("rst_first_rdy0", req0_rdy, 1);
      @(posedge clk);
      #1;

      // Transfer counters
      do_reset();
      req0_vld = 1; out_rdy = 1;
      repeat (101) @(posedge clk);
      #1;
      chk("cnt0_100", cnt0, STATS ? 100 : 0);
      chk("cnt1_idle", cnt1, 0);
`ifdef SWITCH_ARB_STATS_EN
      repeat (69900) @(posedge clk);
      #1;
      chk("cnt0_saturate", cnt0, 16'hFFFF);
      chk("cnt1_after_sat", cnt1, 0);
`endif

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         req0_vld  = ($urandom_range(0, 3) != 0);
         req1_vld  = ($urandom_range(0, 3) != 0);
         out_rdy   = ($urandom_range(0, 3) != 0);
         req0_addr = 8'($urandom);
         req1_addr = 8'($urandom);
         req0_data = 16'($urandom);
         req1_data = 16'($urandom);
         model_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
